hilo_muldiv_ctrl: RTL

Sequencer and arbiter for the HI/LO register in the dual-issue execute stage. Accepts multiply, divide and MTHI/MTLO operations from the primary and secondary issue slots, executes them in program order (primary first) on a shared 32x32 multiplier and an iterative radix-2 divider, stalls the pipeline while busy, and drives the two 65-bit HI/LO write buses ({wdata[63:0], we}) consumed by the HI/LO register file. The secondary result already includes the primary's effect, so the register's secondary-wins priority is always correct.

---
 rtl/hilo_muldiv_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl
// Sequencer/arbiter for the HI/LO register of the dual-issue execute stage.
// Runs the primary slot op, then the secondary slot op, on a shadow copy of
// {HI,LO}. Multiplies finish in one cycle. Divides use a restoring radix-2
// divider of 32 iterations plus one sign-fixup cycle. Both results are then
// presented together for one cycle on the HI/LO write buses. The secondary
// result already includes the primary's effect.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   flush_i          synchronous abort; returns to IDLE, suppresses writes
//   pri_op_i/rs/rt   primary slot op (0 NOP,1 MULT,2 MULTU,3 DIV,4 DIVU,
//                    5 MTHI,6 MTLO,7 NOP) and operands
//   sec_op_i/rs/rt   secondary slot op and operands
//   hilo_i           committed {HI,LO}, sampled when ops are accepted
//   stall_o          combinational pipeline hold request
//   hilo_bus_pri_o   registered {primary result[63:0], we}
//   hilo_bus_sec_o   registered {secondary result[63:0], we}
module hilo_muldiv_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic [2:0]  pri_op_i,
    input  logic [31:0] pri_rs_i,
    input  logic [31:0] pri_rt_i,
    input  logic [2:0]  sec_op_i,
    input  logic [31:0] sec_rs_i,
    input  logic [31:0] sec_rt_i,
    input  logic [63:0] hilo_i,
    output logic        stall_o,
    output logic [64:0] hilo_bus_pri_o,
    output logic [64:0] hilo_bus_sec_o
);

    typedef enum logic [1:0] {IDLE, CALC_P, CALC_S, WRITE} state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    function automatic logic op_valid(input logic [2:0] op);
        return (op != 3'd0) && (op != 3'd7);
    endfunction

    state_t      state;
    logic [2:0]  pri_op_q, sec_op_q;
    logic [31:0] pri_rs_q, pri_rt_q, sec_rs_q, sec_rt_q;
    logic [63:0] shadow_q, pri_res_q, sec_res_q;
    logic [5:0]  cnt_q;
    logic [31:0] rem_q, quo_q;

    // Operands of the op currently executing.
    logic [2:0]  cur_op;
    logic [31:0] cur_rs, cur_rt;
    logic        is_div, div_zero, signed_div, neg_q, neg_r, op_done;
    logic [31:0] abs_rs, abs_rt, cur_rem, cur_quo, rem_next, quo_next;
    logic [31:0] fix_q, fix_r;
    logic [32:0] shifted, diff;
    logic [63:0] mul_s, mul_u, result;

    // NOTE: every signal written in always_comb gets a default before any
    // branch, so no path can leave it unassigned and infer a latch.
    always_comb begin
        cur_op = pri_op_q;
        cur_rs = pri_rs_q;
        cur_rt = pri_rt_q;
        if (state == CALC_S) begin
            cur_op = sec_op_q;
            cur_rs = sec_rs_q;
            cur_rt = sec_rt_q;
        end

        is_div     = (cur_op == OP_DIV) || (cur_op == OP_DIVU);
        signed_div = (cur_op == OP_DIV);
        div_zero   = (cur_rt == 32'd0);
        abs_rs     = (signed_div && cur_rs[31]) ? -cur_rs : cur_rs;
        abs_rt     = (signed_div && cur_rt[31]) ? -cur_rt : cur_rt;
        neg_q      = signed_div && (cur_rs[31] ^ cur_rt[31]);
        neg_r      = signed_div && cur_rs[31];

        // Restoring step; the first iteration starts from rem=0, quo=|rs|.
        cur_rem  = (cnt_q == 6'd0) ? 32'd0  : rem_q;
        cur_quo  = (cnt_q == 6'd0) ? abs_rs : quo_q;
        shifted  = {cur_rem, cur_quo[31]};
        diff     = shifted - {1'b0, abs_rt};
        rem_next = diff[32] ? shifted[31:0] : diff[31:0];
        quo_next = {cur_quo[30:0], ~diff[32]};

        fix_q = neg_q ? -quo_q : quo_q;
        fix_r = neg_r ? -rem_q : rem_q;

        mul_s = {{32{cur_rs[31]}}, cur_rs} * {{32{cur_rt[31]}}, cur_rt};
        mul_u = {32'd0, cur_rs} * {32'd0, cur_rt};

        op_done = !(is_div && !div_zero) || (cnt_q == 6'd32);

        case (cur_op)
            OP_MULT:         result = mul_s;
            OP_MULTU:        result = mul_u;
            OP_DIV, OP_DIVU: result = div_zero ? {cur_rs, 32'hFFFF_FFFF} : {fix_r, fix_q};
            OP_MTHI:         result = {cur_rs, shadow_q[31:0]};
            OP_MTLO:         result = {shadow_q[63:32], cur_rs};
            default:         result = shadow_q;
        endcase
    end

    assign stall_o = !rst && (((state == IDLE) && (op_valid(pri_op_i) || op_valid(sec_op_i)))
                              || (state == CALC_P) || (state == CALC_S));

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            state          <= IDLE;
            hilo_bus_pri_o <= '0;
            hilo_bus_sec_o <= '0;
            pri_op_q       <= '0;
            sec_op_q       <= '0;
            pri_rs_q       <= '0;
            pri_rt_q       <= '0;
            sec_rs_q       <= '0;
            sec_rt_q       <= '0;
            shadow_q       <= '0;
            pri_res_q      <= '0;
            sec_res_q      <= '0;
            cnt_q          <= '0;
            rem_q          <= '0;
            quo_q          <= '0;
        end else begin
            // Bus write enables are single-cycle pulses.
            hilo_bus_pri_o <= '0;
            hilo_bus_sec_o <= '0;
            case (state)
                IDLE: begin
                    if (op_valid(pri_op_i) || op_valid(sec_op_i)) begin
                        pri_op_q <= pri_op_i;
                        pri_rs_q <= pri_rs_i;
                        pri_rt_q <= pri_rt_i;
                        sec_op_q <= sec_op_i;
                        sec_rs_q <= sec_rs_i;
                        sec_rt_q <= sec_rt_i;
                        shadow_q <= hilo_i;
                        cnt_q    <= '0;
                        state    <= op_valid(pri_op_i) ? CALC_P : CALC_S;
                    end
                end
                CALC_P, CALC_S: begin
                    if (!op_done) begin
                        rem_q <= rem_next;
                        quo_q <= quo_next;
                        cnt_q <= cnt_q + 6'd1;
                    end else begin
                        cnt_q <= '0;
                        if (state == CALC_P) begin
                            shadow_q  <= result;
                            pri_res_q <= result;
                            if (op_valid(sec_op_q)) begin
                                state <= CALC_S;
                            end else begin
                                state          <= WRITE;
                                hilo_bus_pri_o <= {result, 1'b1};
                            end
                        end else begin
                            sec_res_q      <= result;
                            state          <= WRITE;
                            hilo_bus_sec_o <= {result, 1'b1};
                            if (op_valid(pri_op_q))
                                hilo_bus_pri_o <= {pri_res_q, 1'b1};
                        end
                    end
                end
                default: state <= IDLE;  // WRITE
            endcase
        end
    end

endmodule
